circular_buffer: RTL and testbench

Synchronous single-clock FIFO built on a circular RAM with wrapping read/write pointers and a full/empty occupancy tracker. Generic data-type storage queue, used as the base structure for the processor's in-order queues (instruction buffers, ROB-style queues, free lists). Data is first-word-fall-through: the head entry is always visible on read_data; read_en pops it.

---
 rtl/circular_buffer.sv | 82 ++++++++
 tb/tb_circular_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/circular_buffer.sv
// Single-clock first-word-fall-through FIFO on a circular RAM.
// The head entry is always driven on read_data; read_en pops it.
// Pointers wrap by explicit compare, so DEPTH need not be a power of two.
module circular_buffer #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic write_en,
  input  T     write_data,
  input  logic read_en,
  output T     read_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_wr, do_rd;

  // Flags come straight from the registered occupancy count.
  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  // Requests against a full/empty queue are simply not accepted.
  assign do_wr = write_en & ~full;
  assign do_rd = read_en & ~empty;

  // Head element is visible combinationally (zero-cycle read latency).
  assign read_data = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_wr) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end

    // Simultaneous push and pop leaves the count unchanged.
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; asynchronous reset empties the queue instantly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_circular_buffer.sv
// Self-checking bench for circular_buffer: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_circular_buffer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        write_en;
  logic [31:0] write_data;
  logic        read_en;
  logic [31:0] read_data;
  logic        full;
  logic        empty;

  int total = 0;
  int bad   = 0;

  // Reference model: the queue contents, oldest first.
  logic [31:0] model_q[$];

  circular_buffer #(
    .T    (logic [31:0]),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write_en  (write_en),
    .write_data(write_data),
    .read_en   (read_en),
    .read_data (read_data),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of traffic: inputs applied at the falling edge, head
  // observed just before the rising edge, model advanced on pre-edge state.
  task automatic cycle(input logic we, input logic [31:0] wd, input logic re,
                       output logic [31:0] head_obs);
    bit dw, dr;
    @(negedge clk);
    write_en   = we;
    write_data = wd;
    read_en    = re;
    #1;
    head_obs = read_data;
    dw = we && (model_q.size() < DEPTH);
    dr = re && (model_q.size() > 0);
    @(posedge clk);
    if (dr) void'(model_q.pop_front());
    if (dw) model_q.push_back(wd);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    write_en   = 1'b1;
    read_en    = 1'b1;
    write_data = 32'hdead_beef;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    rst_n    = 1'b1;
    model_q.delete();
    @(posedge clk);
    #1;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL post_reset_empty got=%b exp=1", empty); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL post_reset_full got=%b exp=0", full); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] h;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (full !== 1'b0) begin bad++; $display("FAIL fill_not_full i=%0d got=%b exp=0", i, full); end
      cycle(1'b1, 32'(i), 1'b0, h);
    end
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++;
    if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", empty); end
    // Push while full must be dropped.
    cycle(1'b1, 32'd8, 1'b0, h);
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL overflow_full got=%b exp=1", full); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (empty !== 1'b0) begin bad++; $display("FAIL drain_not_empty i=%0d got=%b exp=0", i, empty); end
      cycle(1'b0, 32'd0, 1'b1, h);
      total++;
      if (h !== 32'(i)) begin bad++; $display("FAIL drain_order i=%0d got=%0d exp=%0d", i, h, i); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", empty); end
    // Pop while empty must not move the read pointer.
    cycle(1'b0, 32'd0, 1'b1, h);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL underflow_empty got=%b exp=1", empty); end
    cycle(1'b1, 32'd77, 1'b0, h);
    total++;
    if (read_data !== 32'd77) begin bad++; $display("FAIL underflow_head got=%0d exp=77", read_data); end
    cycle(1'b0, 32'd0, 1'b1, h);
    total++;
    if (h !== 32'd77) begin bad++; $display("FAIL underflow_pop got=%0d exp=77", h); end
  endtask

  task automatic test_wrap();
    logic [31:0] h;
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'(10 + i), 1'b0, h);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'd0, 1'b1, h);
      total++;
      if (h !== 32'(10 + i)) begin bad++; $display("FAIL wrap_pre i=%0d got=%0d exp=%0d", i, h, 10 + i); end
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(100 + i), 1'b0, h);
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", full); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 32'd0, 1'b1, h);
      total++;
      if (h !== 32'(100 + i)) begin bad++; $display("FAIL wrap_order i=%0d got=%0d exp=%0d", i, h, 100 + i); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(200 + i), 1'b0, h);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 32'(300 + k), 1'b1, h);
      total++;
      if (h !== ((k < 3) ? 32'(200 + k) : 32'(300 + k - 3))) begin
        bad++; $display("FAIL b2b_head k=%0d got=%0d", k, h);
      end
    end
    total++;
    if (full !== 1'b0 || empty !== 1'b0) begin
      bad++; $display("FAIL b2b_flags got=%b%b exp=00", full, empty);
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (empty !== 1'b0) begin bad++; $display("FAIL b2b_count j=%0d got empty=%b exp=0", j, empty); end
      cycle(1'b0, 32'd0, 1'b1, h);
      total++;
      if (h !== 32'(307 + j)) begin bad++; $display("FAIL b2b_drain j=%0d got=%0d exp=%0d", j, h, 307 + j); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end

    // Push+pop while full: pop wins, push dropped.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(400 + i), 1'b0, h);
    cycle(1'b1, 32'd999, 1'b1, h);
    total++;
    if (h !== 32'd400) begin bad++; $display("FAIL full_pp_head got=%0d exp=400", h); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL full_pp_full got=%b exp=0", full); end
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 32'd0, 1'b1, h);
      total++;
      if (h !== 32'(400 + i)) begin bad++; $display("FAIL full_pp_drain i=%0d got=%0d exp=%0d", i, h, 400 + i); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL full_pp_empty got=%b exp=1", empty); end

    // Push+pop while empty: push wins, pop ignored.
    cycle(1'b1, 32'd42, 1'b1, h);
    total++;
    if (empty !== 1'b0) begin bad++; $display("FAIL empty_pp_empty got=%b exp=0", empty); end
    total++;
    if (read_data !== 32'd42) begin bad++; $display("FAIL empty_pp_head got=%0d exp=42", read_data); end
    cycle(1'b0, 32'd0, 1'b1, h);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL empty_pp_single got=%b exp=1", empty); end
  endtask

  task automatic test_async_reset();
    logic [31:0] h;
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(500 + i), 1'b0, h);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL async_empty got=%b exp=1", empty); end
    total++;
    if (full !== 1'b0) begin bad++; $display("FAIL async_full got=%b exp=0", full); end
    #1;
    rst_n = 1'b1;
    model_q.delete();
    cycle(1'b1, 32'd55, 1'b0, h);
    cycle(1'b0, 32'd0, 1'b1, h);
    total++;
    if (h !== 32'd55) begin bad++; $display("FAIL async_pop got=%0d exp=55", h); end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL async_after_empty got=%b exp=1", empty); end
  endtask

  task automatic test_random();
    logic [31:0] h, exp_h, wd;
    bit exp_has, we, re;
    int pw;
    for (int phase = 0; phase < 3; phase++) begin
      pw = 70 - phase * 20;
      for (int n = 0; n < 150; n++) begin
        exp_has = (model_q.size() > 0);
        exp_h   = exp_has ? model_q[0] : 32'd0;
        we      = ($urandom_range(0, 99) < pw);
        re      = ($urandom_range(0, 99) < 50);
        wd      = $urandom;
        cycle(we, wd, re, h);
        if (exp_has) begin
          total++;
          if (h !== exp_h) begin bad++; $display("FAIL rand_head n=%0d got=%h exp=%h", n, h, exp_h); end
        end
        total++;
        if (full !== (model_q.size() == DEPTH)) begin
          bad++; $display("FAIL rand_full n=%0d got=%b exp=%b", n, full, model_q.size() == DEPTH);
        end
        total++;
        if (empty !== (model_q.size() == 0)) begin
          bad++; $display("FAIL rand_empty n=%0d got=%b exp=%b", n, empty, model_q.size() == 0);
        end
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    write_en   = 1'b0;
    read_en    = 1'b0;
    write_data = '0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
